iregfile_mp: RTL and testbench

IREGFILE_MP -- requirements
Module: iregfile_mp

---
 rtl/iregfile_mp.sv | 114 +++++++++++
 tb/tb_iregfile_mp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iregfile_mp.sv
// Multi-ported integer register file with hard-wired zero register,
// same-cycle write forwarding and a per-register operand-pending scoreboard.
module iregfile_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int RD_LAT = 0,
    parameter int BYPASS = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD-1:0]            re,
    input  logic [NRD-1:0][AW-1:0]    ra,
    output logic [NRD-1:0][WIDTH-1:0] rs,
    output logic [NRD-1:0]            rbusy,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    wa,
    input  logic [NWR-1:0][WIDTH-1:0] wd,
    input  logic                      pset,
    input  logic [AW-1:0]             paddr
);

    logic [WIDTH-1:0]            mem     [DEPTH];
    logic [WIDTH-1:0]            wr_data [DEPTH];
    logic [DEPTH-1:0]            wr_en;
    logic [DEPTH-1:0]            pend;
    logic [NRD-1:0][WIDTH-1:0]   rd_p0;
    logic [NRD-1:0]              busy_p0;

    // Address is a real, writable register (excludes the zero register and holes above DEPTH).
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && (a != '0);
    endfunction

    // Per-register enable/data; later ports overwrite earlier ones so the highest index wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j] == AW'(i))) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = wd[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en[i]) mem[i] <= wr_data[i];
                if (pset && (paddr == AW'(i))) pend[i] <= 1'b1;
                else if (wr_en[i])             pend[i] <= 1'b0;
            end
        end
    end

    // Stage p0: combinational read with optional forwarding of the winning write.
    always_comb begin
        logic             hit;
        logic [WIDTH-1:0] fwd;
        for (int k = 0; k < NRD; k++) begin
            hit        = 1'b0;
            fwd        = '0;
            rd_p0[k]   = '0;
            busy_p0[k] = 1'b0;
            if (rst_n && re[k] && addr_live(ra[k])) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j] == ra[k])) begin
                        hit = 1'b1;
                        fwd = wd[j];
                    end
                end
                rd_p0[k]   = (BYPASS != 0 && hit) ? fwd : mem[ra[k]];
                busy_p0[k] = pend[ra[k]] & ~(BYPASS != 0 && hit);
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_comb
            assign rs    = rd_p0;
            assign rbusy = busy_p0;
        end else begin : g_reg
            logic [NRD-1:0][WIDTH-1:0] rd_p1;
            logic [NRD-1:0]            busy_p1;
            // Stage p1: registered read data, held while the port is idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_p1   <= '0;
                    busy_p1 <= '0;
                end else begin
                    for (int k = 0; k < NRD; k++) begin
                        if (re[k]) begin
                            rd_p1[k]   <= rd_p0[k];
                            busy_p1[k] <= busy_p0[k];
                        end
                    end
                end
            end
            assign rs    = rd_p1;
            assign rbusy = busy_p1;
        end
    endgenerate

endmodule

// File: tb/tb_iregfile_mp.sv
// Scoreboard bench for iregfile_mp (default parameters, combinational read, bypass on).
module tb_iregfile_mp;

    localparam int W = 32;
    localparam int D = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       re;
    logic [1:0][4:0]  ra;
    logic [1:0][31:0] rs;
    logic [1:0]       rbusy;
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] wd;
    logic             pset;
    logic [4:0]       paddr;

    typedef struct {
        logic [1:0][31:0] rs;
        logic [1:0]       rb;
        string            tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem  [D];
    logic        mdl_pend [D];
    int          errors = 0;
    int          checks = 0;

    iregfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .NWR(2), .RD_LAT(0), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rs(rs), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .pset(pset), .paddr(paddr)
    );

    always #5 clk = ~clk;

    task automatic mdl_clear();
        for (int i = 0; i < D; i++) begin
            mdl_mem[i]  = '0;
            mdl_pend[i] = 1'b0;
        end
    endtask

    // Reference: register 0 reads as zero, last-listed write port wins, reads see that write now.
    function automatic exp_t predict(input string tag);
        exp_t e;
        e.tag = tag;
        for (int k = 0; k < 2; k++) begin
            logic hit;
            logic [31:0] f;
            hit = 1'b0;
            f = '0;
            e.rs[k] = '0;
            e.rb[k] = 1'b0;
            if (rst_n && re[k] && ra[k] != 0) begin
                for (int j = 0; j < 2; j++)
                    if (we[j] && wa[j] == ra[k]) begin hit = 1'b1; f = wd[j]; end
                e.rs[k] = hit ? f : mdl_mem[ra[k]];
                e.rb[k] = mdl_pend[ra[k]] && !hit;
            end
        end
        return e;
    endfunction

    task automatic mdl_clock();
        for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] != 0) begin
                mdl_mem[wa[j]]  = wd[j];
                mdl_pend[wa[j]] = 1'b0;
            end
        end
        if (pset && paddr != 0) mdl_pend[paddr] = 1'b1;
    endtask

    task automatic idle();
        re = '0; ra = '0; we = '0; wa = '0; wd = '0; pset = 1'b0; paddr = '0;
    endtask

    // Issue one cycle with the inputs currently set up.
    task automatic drive(input string tag);
        if (|re) sb.push_back(predict(tag));
        @(posedge clk);
        if (rst_n) mdl_clock();
        #1;
    endtask

    task automatic rd(input logic [1:0] e, input logic [4:0] a0, input logic [4:0] a1,
                      input string tag);
        idle();
        re = e; ra[0] = a0; ra[1] = a1;
        drive(tag);
    endtask

    // Monitor: the DUT presents data mid-cycle whenever a read port is enabled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (|re) begin
                if (sb.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL scoreboard_underflow: read seen with nothing expected at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k < 2; k++) begin
                        checks++;
                        if (rs[k] !== e.rs[k]) begin
                            errors++;
                            $display("FAIL %s rs[%0d]: got %h expected %h", e.tag, k, rs[k], e.rs[k]);
                        end
                        checks++;
                        if (rbusy[k] !== e.rb[k]) begin
                            errors++;
                            $display("FAIL %s rbusy[%0d]: got %b expected %b", e.tag, k, rbusy[k], e.rb[k]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        idle();
        mdl_clear();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < D; a++) rd(2'b11, 5'(a), 5'(D - 1 - a), "reset_read_all");

        idle(); we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; drive("wr5");
        rd(2'b01, 5'd5, 5'd0, "read5");

        idle(); we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22;
        re = 2'b10; ra[1] = 5'd7; drive("bypass7");
        rd(2'b11, 5'd7, 5'd5, "reg7_after");

        idle(); we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; re = 2'b01; ra[0] = 5'd0;
        drive("write_r0");
        idle(); pset = 1'b1; paddr = 5'd0; re = 2'b11; drive("pset_r0");
        rd(2'b11, 5'd0, 5'd0, "read_r0");

        idle(); pset = 1'b1; paddr = 5'd3; drive("pset3");
        rd(2'b01, 5'd3, 5'd0, "pend3");
        idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5; pset = 1'b1; paddr = 5'd3;
        re = 2'b01; ra[0] = 5'd3; drive("wr3_pset3");
        rd(2'b11, 5'd3, 5'd3, "still_busy3");
        idle(); we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'h5A5A; drive("wr3_alone");
        rd(2'b11, 5'd3, 5'd3, "cleared3");

        for (int n = 0; n < 400; n++) begin
            re    = 2'($urandom);
            ra[0] = 5'($urandom_range(0, 7));
            ra[1] = 5'($urandom_range(0, 31));
            we    = 2'($urandom);
            wa[0] = 5'($urandom_range(0, 7));
            wa[1] = 5'($urandom_range(0, 7));
            wd[0] = $urandom;
            wd[1] = $urandom;
            pset  = ($urandom_range(0, 3) == 0);
            paddr = 5'($urandom_range(0, 7));
            drive("random");
        end

        idle(); we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h1234; pset = 1'b1; paddr = 5'd12; drive("pre_rst_a");
        idle(); pset = 1'b1; paddr = 5'd9; drive("pre_rst_b");
        rd(2'b11, 5'd9, 5'd12, "pre_rst_busy");
        idle(); re = 2'b11; ra[0] = 5'd9; ra[1] = 5'd12;
        we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h5555; pset = 1'b1; paddr = 5'd20;
        rst_n = 1'b0;
        mdl_clear();
        drive("async_rst");
        idle(); we[0] = 1'b1; wa[0] = 5'd20; wd[0] = 32'hBAD; drive("in_rst_write");
        rst_n = 1'b1;
        rd(2'b11, 5'd9, 5'd20, "post_rst_a");
        rd(2'b11, 5'd12, 5'd5, "post_rst_b");
        idle(); we[0] = 1'b1; wa[0] = 5'd20; wd[0] = 32'hC0FFEE; drive("first_write");
        rd(2'b01, 5'd20, 5'd0, "first_write_rd");

        idle();
        for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
